// File: rtl/turret_cmd_sequencer.sv
// turret_cmd_sequencer: keycode -> rotate steps, angle index, fire handshake.
// Optional build macro TURRET_AUTOFIRE_EN: re-fire while fire key is held.
module turret_cmd_sequencer #(
   parameter logic [7:0] KEY_CCW      = 8'h52,
   parameter logic [7:0] KEY_CW       = 8'h51,
   parameter logic [7:0] KEY_FIRE     = 8'h2C,
   parameter int         MAX_IDX      = 8,
   parameter int         RESET_IDX    = 4,
   parameter int         REPEAT_DELAY = 20,
   parameter int         REPEAT_RATE  = 6,
   parameter int         COOLDOWN     = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   output logic [3:0] angle_idx,
   output logic       step_ccw,
   output logic       step_cw,
   output logic       fire_req,
   input  logic       fire_ack,
   output logic       fire_ready
);

   localparam logic [3:0] L_MAX  = 4'(MAX_IDX);
   localparam logic [3:0] L_RST  = 4'(RESET_IDX);
   localparam logic [7:0] L_DLY  = 8'(REPEAT_DELAY);
   localparam logic [7:0] L_RATE = 8'(REPEAT_RATE);
   localparam logic [7:0] L_COOL = 8'(COOLDOWN);

   typedef enum logic [1:0] {D_NONE, D_CCW, D_CW} dir_t;
   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rot_st_t;
   typedef enum logic [1:0] {F_READY, F_REQ, F_COOL} fire_st_t;

   dir_t      r_rot_dir;
   logic      r_fire_key;
   rot_st_t   r_rot_st;
   logic [7:0] r_rot_cnt;
   logic [3:0] r_idx;
   logic      r_step_ccw;
   logic      r_step_cw;
   fire_st_t  r_fire_st;
   logic [7:0] r_fire_cnt;

   dir_t      w_dir;
   logic      w_fire;
   logic      w_rot_chg;
   logic      w_fire_edge;
   rot_st_t   w_rot_nx;
   logic [7:0] w_rot_cnt_nx;
   dir_t      w_step_dir;
   logic      w_do_ccw;
   logic      w_do_cw;
   logic [3:0] w_idx_nx;
   fire_st_t  w_fire_nx;
   logic [7:0] w_fire_cnt_nx;

   // Decode the held keycode into a single rotate direction
   always_comb begin
      w_dir = D_NONE;
      unique case (1'b1)
         (keycode == KEY_CCW): w_dir = D_CCW;
         (keycode == KEY_CW):  w_dir = D_CW;
         default:              w_dir = D_NONE;
      endcase
   end

   assign w_fire      = (keycode == KEY_FIRE);
   assign w_rot_chg   = (w_dir != r_rot_dir);
   assign w_fire_edge = w_fire & ~r_fire_key;

   // Rotate FSM next state; a key change overrides a same-cycle tick
   always_comb begin
      w_rot_nx     = r_rot_st;
      w_rot_cnt_nx = r_rot_cnt;
      w_step_dir   = D_NONE;
      unique case (r_rot_st)
         R_IDLE: begin
            if (w_rot_chg && (w_dir != D_NONE)) begin
               w_step_dir   = w_dir;
               w_rot_cnt_nx = L_DLY;
               w_rot_nx     = R_DELAY;
            end
         end
         R_DELAY, R_REPEAT: begin
            if (w_rot_chg) begin
               if (w_dir == D_NONE) begin
                  w_rot_nx = R_IDLE;
               end else begin
                  w_step_dir   = w_dir;
                  w_rot_cnt_nx = L_DLY;
                  w_rot_nx     = R_DELAY;
               end
            end else if (frame_tick) begin
               if (r_rot_cnt <= 8'd1) begin
                  w_step_dir   = r_rot_dir;
                  w_rot_cnt_nx = L_RATE;
                  w_rot_nx     = R_REPEAT;
               end else begin
                  w_rot_cnt_nx = r_rot_cnt - 8'd1;
               end
            end
         end
         default: w_rot_nx = R_IDLE;
      endcase
   end

   // Saturating index update; a blocked step produces no pulse
   always_comb begin
      w_do_ccw = (w_step_dir == D_CCW) && (r_idx != 4'd0);
      w_do_cw  = (w_step_dir == D_CW) && (r_idx != L_MAX);
      w_idx_nx = r_idx;
      if (w_do_ccw) begin
         w_idx_nx = r_idx - 4'd1;
      end else if (w_do_cw) begin
         w_idx_nx = r_idx + 4'd1;
      end
   end

   // Fire FSM next state; cooldown counts frames after the ack
   always_comb begin
      w_fire_nx     = r_fire_st;
      w_fire_cnt_nx = r_fire_cnt;
      unique case (r_fire_st)
         F_READY: begin
            if (w_fire_edge) begin
               w_fire_nx = F_REQ;
            end
         end
         F_REQ: begin
            if (fire_ack) begin
               w_fire_cnt_nx = L_COOL;
               w_fire_nx     = F_COOL;
            end
         end
         F_COOL: begin
            if (frame_tick && (w_fire == r_fire_key)) begin
               if (r_fire_cnt <= 8'd1) begin
                  w_fire_cnt_nx = 8'd0;
`ifdef TURRET_AUTOFIRE_EN
                  w_fire_nx = w_fire ? F_REQ : F_READY;
`else
                  w_fire_nx = F_READY;
`endif
               end else begin
                  w_fire_cnt_nx = r_fire_cnt - 8'd1;
               end
            end
         end
         default: w_fire_nx = F_READY;
      endcase
   end

   // State, counters, index and registered step pulses
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_rot_dir  <= D_NONE;
         r_fire_key <= 1'b0;
         r_rot_st   <= R_IDLE;
         r_rot_cnt  <= 8'd0;
         r_idx      <= L_RST;
         r_step_ccw <= 1'b0;
         r_step_cw  <= 1'b0;
         r_fire_st  <= F_READY;
         r_fire_cnt <= 8'd0;
      end else begin
         r_rot_dir  <= w_dir;
         r_fire_key <= w_fire;
         r_rot_st   <= w_rot_nx;
         r_rot_cnt  <= w_rot_cnt_nx;
         r_idx      <= w_idx_nx;
         r_step_ccw <= w_do_ccw;
         r_step_cw  <= w_do_cw;
         r_fire_st  <= w_fire_nx;
         r_fire_cnt <= w_fire_cnt_nx;
      end
   end

   assign angle_idx  = r_idx;
   assign step_ccw   = r_step_ccw;
   assign step_cw    = r_step_cw;
   assign fire_req   = (r_fire_st == F_REQ);
   assign fire_ready = (r_fire_st == F_READY);

endmodule

// File: tb/tb_turret_cmd_sequencer.sv
// tb_turret_cmd_sequencer: directed checks of rotate and fire sequencing.
// One frame_tick every 4 clocks; inputs driven on the falling edge.
module tb_turret_cmd_sequencer;

   logic       Clk;
   logic       Reset;
   logic       frame_tick;
   logic [7:0] keycode;
   logic [3:0] angle_idx;
   logic       step_ccw;
   logic       step_cw;
   logic       fire_req;
   logic       fire_ack;
   logic       fire_ready;

   int checks = 0;
   int fails  = 0;

   int nframe = 0;
   int cw_n   = 0;
   int ccw_n  = 0;
   int req_n  = 0;
   int cw_fr [0:63];

   turret_cmd_sequencer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .angle_idx  (angle_idx),
      .step_ccw   (step_ccw),
      .step_cw    (step_cw),
      .fire_req   (fire_req),
      .fire_ack   (fire_ack),
      .fire_ready (fire_ready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count frames and output pulses; record the frame of each CW step
   always @(posedge Clk) begin
      if (frame_tick) nframe <= nframe + 1;
      if (step_cw) begin
         cw_fr[cw_n[5:0]] <= nframe;
         cw_n <= cw_n + 1;
      end
      if (step_ccw) ccw_n <= ccw_n + 1;
      if (fire_req) req_n <= req_n + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         cyc(3);
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
      end
   endtask

   function automatic int fr_at(input int k);
      logic [5:0] a;
      a = 6'(k);
      return cw_fr[a];
   endfunction

   int s;
   int c;
   int base;

   initial begin
      Reset      = 1'b0;
      frame_tick = 1'b0;
      keycode    = 8'h00;
      fire_ack   = 1'b0;
      cyc(3);
      check("rst_idx", int'(angle_idx), 4);
      check("rst_ccw", int'(step_ccw), 0);
      check("rst_cw", int'(step_cw), 0);
      check("rst_req", int'(fire_req), 0);
      check("rst_rdy", int'(fire_ready), 1);
      Reset = 1'b1;

      // idle for 100 frames
      s = cw_n;
      c = ccw_n;
      frames(100);
      cyc(1);
      check("idle_idx", int'(angle_idx), 4);
      check("idle_cw", cw_n - s, 0);
      check("idle_ccw", ccw_n - c, 0);
      check("idle_rdy", int'(fire_ready), 1);

      // single-clock CCW tap
      c = ccw_n;
      keycode = 8'h52;
      cyc(1);
      check("tap_pulse", int'(step_ccw), 1);
      check("tap_idx", int'(angle_idx), 3);
      keycode = 8'h00;
      cyc(5);
      check("tap_cnt", ccw_n - c, 1);
      check("tap_idx2", int'(angle_idx), 3);

      keycode = 8'h51;
      cyc(1);
      keycode = 8'h00;
      cyc(3);
      check("cwtap_idx", int'(angle_idx), 4);

      // CW held 40 frames: steps 0,20,26,32 then saturates
      s = cw_n;
      base = nframe;
      keycode = 8'h51;
      frames(40);
      cyc(1);
      check("cw_cnt", cw_n - s, 4);
      check("cw_f0", fr_at(s) - base, 0);
      check("cw_f1", fr_at(s + 1) - base, 20);
      check("cw_f2", fr_at(s + 2) - base, 26);
      check("cw_f3", fr_at(s + 3) - base, 32);
      check("cw_idx", int'(angle_idx), 8);
      keycode = 8'h00;
      cyc(2);

      // CCW held 60 frames: 8 steps down to 0
      c = ccw_n;
      keycode = 8'h52;
      frames(60);
      cyc(1);
      check("ccw_cnt", ccw_n - c, 8);
      check("ccw_idx", int'(angle_idx), 0);
      keycode = 8'h00;
      cyc(2);

      // CCW held at index 0
      c = ccw_n;
      keycode = 8'h52;
      frames(30);
      cyc(1);
      check("sat_cnt", ccw_n - c, 0);
      check("sat_idx", int'(angle_idx), 0);
      keycode = 8'h00;
      cyc(2);

      // direct reversal restarts the delay
      keycode = 8'h51;
      cyc(1);
      check("rev_a", int'(angle_idx), 1);
      frames(10);
      keycode = 8'h52;
      cyc(1);
      check("rev_b", int'(angle_idx), 0);
      check("rev_pls", int'(step_ccw), 1);
      frames(19);
      cyc(1);
      check("rev_c", int'(angle_idx), 0);
      keycode = 8'h51;
      cyc(1);
      check("rev_d", int'(angle_idx), 1);
      frames(19);
      cyc(1);
      check("rev_e", int'(angle_idx), 1);
      frames(1);
      check("rev_f", int'(angle_idx), 2);
      check("rev_pls2", int'(step_cw), 1);
      keycode = 8'h00;
      cyc(2);

      // fire: ack 3 clocks after req
      s = req_n;
      keycode = 8'h2C;
      cyc(1);
      check("f_req", int'(fire_req), 1);
      check("f_rdy", int'(fire_ready), 0);
      cyc(2);
      fire_ack = 1'b1;
      cyc(1);
      fire_ack = 1'b0;
      check("f_drop", int'(fire_req), 0);
      check("f_len", req_n - s, 3);
      keycode = 8'h00;
      cyc(1);
      frames(9);
      keycode = 8'h2C;
      cyc(3);
      check("f_ign", int'(fire_req), 0);
      frames(20);
      check("f_cool29", int'(fire_ready), 0);
      frames(1);
`ifdef TURRET_AUTOFIRE_EN
      check("f_cool30", int'(fire_ready), 0);
      cyc(2);
      check("f_held", int'(fire_req), 1);
      keycode = 8'h00;
      fire_ack = 1'b1;
      cyc(1);
      fire_ack = 1'b0;
      frames(30);
`else
      check("f_cool30", int'(fire_ready), 1);
      cyc(2);
      check("f_held", int'(fire_req), 0);
`endif
      keycode = 8'h00;
      cyc(1);

      // ack already high when req rises
      s = req_n;
      fire_ack = 1'b1;
      keycode = 8'h2C;
      cyc(1);
      check("fa_req", int'(fire_req), 1);
      cyc(1);
      check("fa_drop", int'(fire_req), 0);
      fire_ack = 1'b0;
      cyc(2);
      check("fa_len", req_n - s, 1);
      check("fa_rdy", int'(fire_ready), 0);
      keycode = 8'h00;
      frames(30);
      check("fa_back", int'(fire_ready), 1);

      // async reset while requesting
      keycode = 8'h2C;
      cyc(1);
      check("rr_req", int'(fire_req), 1);
      #2 Reset = 1'b0;
      #1;
      check("rr_req0", int'(fire_req), 0);
      check("rr_rdy", int'(fire_ready), 1);
      check("rr_idx", int'(angle_idx), 4);
      @(negedge Clk);
      keycode = 8'h00;
      Reset = 1'b1;
      cyc(2);

      // key change beats a same-cycle frame tick
      keycode = 8'h51;
      cyc(1);
      check("co_a", int'(angle_idx), 5);
      frames(19);
      cyc(3);
      frame_tick = 1'b1;
      keycode = 8'h52;
      cyc(1);
      frame_tick = 1'b0;
      check("co_b", int'(angle_idx), 4);
      frames(19);
      cyc(1);
      check("co_c", int'(angle_idx), 4);
      frames(1);
      check("co_d", int'(angle_idx), 3);
      keycode = 8'h00;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
